// File: rtl/sync_hs_receiver.sv
// Receiver bridging a self-timed 4-phase pipeline into the clocked domain:
// synchronizes the request, acknowledges each token once and buffers it in a FIFO.
module sync_hs_receiver #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lr,
    input  logic [WIDTH-1:0] ld,
    output logic             la,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             full,
    output logic [15:0]      tok_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        IDLE   = 2'd1,
        ACK    = 2'd2
    } state_t;

    state_t                 state_q;
    logic                   la_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lr_s;
    logic                   push_s;
    logic                   pop_s;

    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   valid_q;
    logic                   full_q;
    logic [15:0]            tok_count_q;
    logic [15:0]            tok_count_d;

    // Request synchronizer; flops reset high so a request held across reset reads as busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{1'b1}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], lr};
        end
    end

    assign lr_s   = sync_q[SYNC_STAGES-1];
    assign push_s = (state_q == IDLE) && lr_s && !full_q;
    assign pop_s  = valid_q && out_ready;

    // Handshake FSM with the acknowledge registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SETTLE;
            la_q    <= 1'b0;
        end else begin
            case (state_q)
                SETTLE: begin
                    la_q    <= 1'b0;
                    state_q <= lr_s ? SETTLE : IDLE;
                end
                IDLE: begin
                    if (push_s) begin
                        state_q <= ACK;
                        la_q    <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        la_q    <= 1'b0;
                    end
                end
                ACK: begin
                    if (!lr_s) begin
                        state_q <= IDLE;
                        la_q    <= 1'b0;
                    end else begin
                        state_q <= ACK;
                        la_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= SETTLE;
                    la_q    <= 1'b0;
                end
            endcase
        end
    end

    // FIFO next-state; push is already gated by full, pop by valid.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    assign tok_count_d = push_s ? (tok_count_q + 16'd1) : tok_count_q;

    // FIFO control state; status flags are registered from the next occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            valid_q     <= 1'b0;
            full_q      <= 1'b0;
            tok_count_q <= 16'd0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            valid_q     <= (count_d != CW'(0));
            full_q      <= (count_d == CW'(DEPTH));
            tok_count_q <= tok_count_d;
        end
    end

    // Storage array; stale entries are unreachable once the pointers reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= ld;
        end
    end

    assign la        = la_q;
    assign out_data  = mem_q[rd_ptr_q];
    assign out_valid = valid_q;
    assign full      = full_q;
    assign tok_count = tok_count_q;

endmodule

// File: doc/sync_hs_receiver.md
SYNC_HS_RECEIVER -- requirements
Module: sync_hs_receiver

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data token width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, FIFO entries; power of two, minimum 2.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, flops in the lr synchronizer; minimum 2.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port lr  input  1  asynchronous 4-phase request from the self-timed pipeline's last stage.
REQ-007 SHALL have port ld  input  WIDTH  bundled data; stable before lr rises and held until la rises.
REQ-008 SHALL have port la  output  1  4-phase acknowledge to the pipeline; driven from a flop.
REQ-009 SHALL have port out_data  output  WIDTH  FIFO head token.
REQ-010 SHALL have port out_valid  output  1  FIFO non-empty.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the head token this cycle.
REQ-012 SHALL have port full  output  1  FIFO holds DEPTH tokens.
REQ-013 SHALL have port tok_count  output  16  total tokens accepted since reset.

Function
REQ-014 SHALL synchronize lr through SYNC_STAGES flops to lr_s; no other logic SHALL use raw lr.
REQ-015 SHALL implement FSM states SETTLE, IDLE and ACK.
REQ-016 SETTLE: la=0; go to IDLE at the first edge where lr_s=0.
REQ-017 IDLE: la=0; at an edge where lr_s=1 and full=0, write ld into the FIFO, increment tok_count and go to ACK.
REQ-018 IDLE with lr_s=1 and full=1 SHALL stay in IDLE with la=0 (backpressure); the write occurs at the first edge with full=0.
REQ-019 ACK: la=1; go to IDLE at the first edge where lr_s=0.
REQ-020 la SHALL be a registered decode of the state: 1 only in ACK.
REQ-021 Latency lr rise -> la rise SHALL be SYNC_STAGES+1 clk edges when not full; lr fall -> la fall SHALL be SYNC_STAGES+1 edges.
REQ-022 Exactly one FIFO write SHALL occur per 4-phase handshake; lr held high SHALL never produce a second write.
REQ-023 Pop SHALL occur on an edge with out_valid=1 and out_ready=1; out_data SHALL then advance to the next entry.
REQ-024 out_ready with out_valid=0 SHALL have no effect.
REQ-025 Simultaneous push and pop SHALL leave the occupancy unchanged; both are performed.
REQ-026 full SHALL be evaluated on the registered occupancy; a same-cycle pop SHALL NOT enable a push when full=1.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH; occupancy SHALL range 0..DEPTH.
REQ-028 out_valid SHALL equal (occupancy != 0); full SHALL equal (occupancy == DEPTH).
REQ-029 FIFO order SHALL be first-in first-out, with no loss or duplication.
REQ-030 tok_count SHALL wrap from 16'hFFFF to 0.

Reset
REQ-031 rst_n=0 SHALL asynchronously force:
  - state=SETTLE
  - la=0, out_valid=0, full=0, tok_count=0
  - pointers and occupancy to 0
  - synchronizer flops to 1
REQ-032 A request held high across reset SHALL NOT be captured; capture resumes only after lr is observed low (SETTLE).
REQ-033 Reset asserted during ACK SHALL drop la immediately; FIFO contents SHALL be discarded.
REQ-034 out_data after reset SHALL be don't-care while out_valid=0.

Verification
REQ-035 Single token, SYNC_STAGES=2, out_ready=1: ld=8'hA5, lr 0->1 -> la rises on the 3rd edge, out_valid=1 with out_data=8'hA5, tok_count=1; lr 1->0 -> la falls on the 3rd edge.
REQ-036 Backpressure, DEPTH=4, out_ready=0: send 5 handshakes of 8'h01..8'h05 -> 4 complete, full=1, la stays 0 on the 5th; pop one -> 5th acked; pops yield 01,02,03,04,05 in order.
REQ-037 Simultaneous push and pop at occupancy 2 -> occupancy stays 2 and the head advances; repeat across pointer wrap for 3*DEPTH tokens with no loss or reorder.
REQ-038 Reset mid-handshake: assert rst_n=0 while la=1 and lr=1 -> la=0 immediately, tok_count=0; release with lr still high -> no capture until lr goes low, then a new handshake with 8'h3C gives tok_count=1 and out_data=8'h3C.
REQ-039 Counter wrap: preload via 65536 handshakes (or force) -> tok_count returns to 16'h0000 after 16'hFFFF.
REQ-040 Randomized lr/ld timing against the self-timed pipeline model with random out_ready -> the scoreboard matches every token and la never toggles except per REQ-016..REQ-019.
